// File: rtl/data_mem_resp_if.sv
// data_mem_resp_if: request/response channel between the memory stage and the data RAM.
//   Request : req_valid, req_ready, req_we, req_addr, req_funct3, req_wdata
//   Response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   master = requester (core memory stage), slave = responder (data_mem_resp).
interface data_mem_resp_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_resp.sv
// data_mem_resp: RV32I data-memory responder, one outstanding transaction.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : data_mem_resp_if.slave (valid/ready request and response channels)
// Word-organised little-endian RAM with byte/half/word lane handling,
// sign/zero extension and alignment/range/funct3 error detection.
// Optional feature macro DMEM_WAIT_EN: adds a WAIT state with a down-counter
// that inserts WAIT_CYCLES cycles between accept and response.
module data_mem_resp #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    data_mem_resp_if.slave bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef DMEM_WAIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

    state_t          state_q, state_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic            accept;
    logic [XLEN-3:0] word_idx;
    logic [1:0]      off;
    logic [2:0]      f3;
    logic            in_range;
    logic [AW-1:0]   ram_idx;
    logic [XLEN-1:0] rd_word;
    logic            f3_ok;
    logic            misaligned;
    logic            acc_err;
    logic            ram_we;
    logic [3:0]      wr_be;
    logic [XLEN-1:0] wr_data;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ld_data;

    // Request decode, RAM read and lane handling
    always_comb begin
        accept   = bus.req_valid && req_ready_q;
        word_idx = bus.req_addr[XLEN-1:2];
        off      = bus.req_addr[1:0];
        f3       = bus.req_funct3;
        in_range = ({2'b00, word_idx} < XLEN'(DEPTH_WORDS));
        ram_idx  = word_idx[AW-1:0];
        rd_word  = mem[ram_idx];

        if (bus.req_we)
            f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            f3_ok = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));

        misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                     ((f3[1:0] == 2'b10) && (off != 2'b00));
        acc_err    = !f3_ok || misaligned || !in_range;
        ram_we     = accept && bus.req_we && !acc_err;

        // Store data is replicated across lanes so the byte enables alone pick the target
        wr_be   = '0;
        wr_data = bus.req_wdata;
        case (f3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << off;
                wr_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.req_wdata[15:0]}};
            end
            default: wr_be = 4'b1111;
        endcase

        byte_sel = 8'(rd_word >> {off, 3'b000});
        half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];
        case (f3)
            3'b000:  ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, half_sel};
            default: ld_data = '0;
        endcase
    end

    // Transaction sequencing
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef DMEM_WAIT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // Also raises req_ready on the first edge out of reset
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    rsp_rdata_d = (acc_err || bus.req_we) ? '0 : ld_data;
                    rsp_err_d   = acc_err;
`ifdef DMEM_WAIT_EN
                    if (WAIT_CYCLES == 0) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                    end
`else
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
`endif
                end
            end
`ifdef DMEM_WAIT_EN
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef DMEM_WAIT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DMEM_WAIT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // RAM is deliberately not reset; a store commits at its accept edge
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_be[i])
                    mem[ram_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
